// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: activation mode codes, gate-neuron FSM states and the
// accumulator width helper.
package lstm_pkg;

  localparam int ACT_IDENTITY = 0;
  localparam int ACT_HSIG     = 1;
  localparam int ACT_HTANH    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_ACT,
    ST_HOLD
  } state_t;

  // Room for n full-scale products plus the aligned bias, with a spare sign bit.
  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n + 1) + 1;
  endfunction

endpackage

// File: rtl/gate_act_sat.sv
// Combinational output stage: rescale the accumulator, apply the activation and
// saturate to DATA_W. Also used by the cell output stage.
module gate_act_sat
  import lstm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ACC_W  = 20,
  parameter int ACT    = ACT_HTANH
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] y,
  output logic              sat
);

  localparam logic signed [ACC_W-1:0] ONE  = ACC_W'(1 << FRAC_W);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  function automatic logic signed [ACC_W-1:0] activate(input logic signed [ACC_W-1:0] r);
    logic signed [ACC_W-1:0] t;
    case (ACT)
      ACT_HSIG: begin
        t = (r >>> 2) + HALF;
        if (t < 0) t = '0;
        else if (t > ONE) t = ONE;
      end
      ACT_HTANH: begin
        t = r;
        if (t < -ONE) t = -ONE;
        else if (t > ONE) t = ONE;
      end
      default: t = r;
    endcase
    return t;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > MAXV) return {1'b1, MAXV[DATA_W-1:0]};
    else if (a < MINV) return {1'b1, MINV[DATA_W-1:0]};
    else return {1'b0, a[DATA_W-1:0]};
  endfunction

  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] a;

  always_comb begin
    r = $signed(acc) >>> FRAC_W;
    a = activate(r);
    {sat, y} = saturate(a);
  end

endmodule

// File: rtl/gate_mac_neuron.sv
// One LSTM gate neuron: act(sum Wx*x + sum Wh*h + b) on a single shared multiplier.
// Optional macro GATE_MAC_NEURON_SAT_FLAG_EN adds the sat_flag output.
module gate_mac_neuron
  import lstm_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FRAC_W      = 4,
  parameter int INPUT_SIZE  = 1,
  parameter int HIDDEN_SIZE = 3,
  parameter int ACT         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W*INPUT_SIZE-1:0]  x,
  input  logic [DATA_W*HIDDEN_SIZE-1:0] h,
  input  logic [DATA_W*INPUT_SIZE-1:0]  wx,
  input  logic [DATA_W*HIDDEN_SIZE-1:0] wh,
  input  logic [DATA_W-1:0]             b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             y
`ifdef GATE_MAC_NEURON_SAT_FLAG_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int N     = INPUT_SIZE + HIDDEN_SIZE;
  localparam int ACC_W = acc_width(DATA_W, N);
  localparam int IDX_W = $clog2(N);

  state_t state, state_nx;
  logic [IDX_W-1:0]         idx;
  logic [DATA_W*N-1:0]      opa, opb;
  logic signed [DATA_W-1:0] bias;
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext;
  logic [DATA_W-1:0]        act_y;
  logic                     act_sat;
  logic signed [DATA_W-1:0] y_q;
  logic                     sat_q;
  logic                     last;

  assign last     = (idx == IDX_W'(N - 1));
  assign prod     = $signed(opa[DATA_W-1:0]) * $signed(opb[DATA_W-1:0]);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Bias is Q.FRAC_W, products are Q.2*FRAC_W.
  assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_MAC;
      ST_MAC:  if (last) state_nx = ST_BIAS;
      ST_BIAS: state_nx = ST_ACT;
      ST_ACT:  state_nx = ST_HOLD;
      ST_HOLD: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_HOLD);
  end

  // Operand capture: the shift register presents element idx in its low slot.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      opa  <= {h, x};
      opb  <= {wh, wx};
      bias <= $signed(b);
    end else if (state == ST_MAC) begin
      opa <= opa >> DATA_W;
      opb <= opb >> DATA_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      idx   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          acc   <= '0;
          idx   <= '0;
          sat_q <= 1'b0;
        end
        ST_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        ST_BIAS: acc <= acc + bias_ext;
        ST_ACT: begin
          y_q   <= $signed(act_y);
          sat_q <= act_sat;
        end
        default: ;
      endcase
    end
  end

  gate_act_sat #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W),
    .ACT   (ACT)
  ) u_act (
    .acc(acc),
    .y  (act_y),
    .sat(act_sat)
  );

  assign y = y_q;

`ifdef GATE_MAC_NEURON_SAT_FLAG_EN
  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_gate_mac_neuron.sv
// Bench for gate_mac_neuron: three instances (identity, hard sigmoid, hard tanh)
// share stimulus; results are checked against a table and an arithmetic model.
module tb_gate_mac_neuron;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [7:0]  x, wx, b;
  logic [23:0] h, wh;
  logic        in_ready_a [3];
  logic        out_valid_a[3];
  logic signed [7:0] y_a [3];
  logic        sat_a [3];

  int tot = 0;
  int bad = 0;

  gate_mac_neuron #(.ACT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .x(x), .h(h), .wx(wx), .wh(wh), .b(b),
    .out_valid(out_valid_a[0]), .out_ready(out_ready), .y(y_a[0])
`ifdef GATE_MAC_NEURON_SAT_FLAG_EN
    , .sat_flag(sat_a[0])
`endif
  );
  gate_mac_neuron #(.ACT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .x(x), .h(h), .wx(wx), .wh(wh), .b(b),
    .out_valid(out_valid_a[1]), .out_ready(out_ready), .y(y_a[1])
`ifdef GATE_MAC_NEURON_SAT_FLAG_EN
    , .sat_flag(sat_a[1])
`endif
  );
  gate_mac_neuron #(.ACT(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .x(x), .h(h), .wx(wx), .wh(wh), .b(b),
    .out_valid(out_valid_a[2]), .out_ready(out_ready), .y(y_a[2])
`ifdef GATE_MAC_NEURON_SAT_FLAG_EN
    , .sat_flag(sat_a[2])
`endif
  );

  typedef struct {
    int x, wx, h0, h1, h2, wh0, wh1, wh2, b;
    int e0, e1, e2, es;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    tot++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Real-valued gate: sum in Q.8, rescale by floor, activate, clamp to int8.
  function automatic int model(input int act, input vec_t v, output int sat);
    longint s, r, a;
    s = longint'(v.x) * v.wx + longint'(v.h0) * v.wh0 + longint'(v.h1) * v.wh1
        + longint'(v.h2) * v.wh2 + longint'(v.b) * 16;
    r = fdiv(s, 16);
    if (act == 1)      a = clip(fdiv(r, 4) + 8, 0, 16);
    else if (act == 2) a = clip(r, -16, 16);
    else               a = r;
    sat = (a > 127 || a < -128) ? 1 : 0;
    return int'(clip(a, -128, 127));
  endfunction

  function automatic int rnd8();
    logic [7:0] t;
    t = 8'($urandom_range(0, 255));
    return int'($signed(t));
  endfunction

  task automatic apply(input vec_t v);
    x  = 8'(v.x);
    wx = 8'(v.wx);
    h  = {8'(v.h2), 8'(v.h1), 8'(v.h0)};
    wh = {8'(v.wh2), 8'(v.wh1), 8'(v.wh0)};
    b  = 8'(v.b);
  endtask

  task automatic start_and_wait(input vec_t v, output int lat);
    @(negedge clk);
    apply(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid_a[0] && lat < 50);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_y_id"},   int'(y_a[0]), v.e0);
    chk({tag, "_y_hsig"}, int'(y_a[1]), v.e1);
    chk({tag, "_y_htanh"}, int'(y_a[2]), v.e2);
`ifdef GATE_MAC_NEURON_SAT_FLAG_EN
    chk({tag, "_sat"}, int'(sat_a[0]), v.es);
`endif
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid_a[0]) seen++;
    end
    chk({tag, "_no_out_valid"}, seen, 0);
  endtask

  vec_t tbl[7];
  vec_t v;
  vec_t bb[3];
  int   lat, s, held_y;
  int   q_y[$];
  int   q_t[$];
  int   k;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //        x    wx   h0  h1  h2  wh0 wh1 wh2  b     id  hsig htanh sat
    tbl[0] = '{16,  16,  16, 16, 16, 16, 16, 16,  0,   64,  16,  16,  0};
    tbl[1] = '{16,  16,  16, 16, 16, 16, 16, 16, -32,  32,  16,  16,  0};
    tbl[2] = '{0,   0,   0,  0,  0,  0,  0,  0,   0,   0,   8,   0,   0};
    tbl[3] = '{-128,127, 0,  0,  0,  0,  0,  0,   0,  -128, 0,  -16,  1};
    tbl[4] = '{16, -16,  0,  0,  0,  0,  0,  0,   0,  -16,  4,  -16,  0};
    tbl[5] = '{-1,  1,   0,  0,  0,  0,  0,  0,   0,  -1,   7,  -1,   0};
    tbl[6] = '{127, 127, 127,127,127,127,127,127,127, 127,  16,  16,  1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; wx = '0; h = '0; wh = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_in_ready%0d", i), int'(in_ready_a[i]), 1);
      chk($sformatf("reset_out_valid%0d", i), int'(out_valid_a[i]), 0);
      chk($sformatf("reset_y%0d", i), int'(y_a[i]), 0);
    end

    for (int i = 0; i < 7; i++) begin
      start_and_wait(tbl[i], lat);
      chk($sformatf("tbl%0d_latency", i), lat, 6);
      check_result($sformatf("tbl%0d", i), tbl[i]);
      release_result();
    end

    for (int i = 0; i < 20; i++) begin
      v.x = rnd8(); v.wx = rnd8(); v.b = rnd8();
      v.h0 = rnd8(); v.h1 = rnd8(); v.h2 = rnd8();
      v.wh0 = rnd8(); v.wh1 = rnd8(); v.wh2 = rnd8();
      v.e0 = model(0, v, v.es);
      v.e1 = model(1, v, s);
      v.e2 = model(2, v, s);
      start_and_wait(v, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 6);
      check_result($sformatf("rnd%0d", i), v);
      release_result();
    end

    // Backpressure: result must hold for 5 cycles, ignoring an in_valid pulse.
    start_and_wait(tbl[0], lat);
    held_y = int'(y_a[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin apply(tbl[3]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      chk($sformatf("bp%0d_out_valid", i), int'(out_valid_a[0]), 1);
      chk($sformatf("bp%0d_y", i), int'(y_a[0]), 64);
      chk($sformatf("bp%0d_in_ready", i), int'(in_ready_a[0]), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_y_held", int'(y_a[0]), held_y);
    release_result();
    chk("bp_in_ready_after", int'(in_ready_a[0]), 1);
    quiet_window("bp", 12);

    // Reset while the MAC is at index 2.
    @(negedge clk);
    apply(tbl[1]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", int'(in_ready_a[0]), 1);
    chk("midrst_out_valid", int'(out_valid_a[0]), 0);
    chk("midrst_y", int'(y_a[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    quiet_window("midrst", 12);
    start_and_wait(tbl[4], lat);
    chk("postrst_latency", lat, 6);
    check_result("postrst", tbl[4]);
    release_result();

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      bb[i].x = rnd8(); bb[i].wx = rnd8(); bb[i].b = rnd8();
      bb[i].h0 = rnd8(); bb[i].h1 = rnd8(); bb[i].h2 = rnd8();
      bb[i].wh0 = rnd8(); bb[i].wh1 = rnd8(); bb[i].wh2 = rnd8();
      bb[i].e0 = model(0, bb[i], bb[i].es);
    end
    out_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 80 && q_y.size() < 3; cyc++) begin
      @(negedge clk);
      if (out_valid_a[0]) begin
        q_y.push_back(int'(y_a[0]));
        q_t.push_back(cyc);
      end
      if (in_ready_a[0] && k < 3) begin
        apply(bb[k]);
        in_valid = 1'b1;
        k++;
      end else if (in_ready_a[0]) begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", q_y.size(), 3);
    if (q_y.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("b2b%0d_y", i), q_y[i], bb[i].e0);
      chk("b2b_spacing", q_t[2] - q_t[1], q_t[1] - q_t[0]);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
